// File: rtl/multdiv_seq_param.sv
// Iterative multiplier/divider for the HI/LO unit, generic operand width.
//
// A multiply takes WIDTH cycles (radix 2) or WIDTH/2 cycles (radix 4). A divide is a
// WIDTH-cycle restoring divide. One FIX cycle follows either of them to apply the result
// signs. The results are held in output registers. They change only when an operation
// completes.
//
// Ports
//   clk           rising-edge clock
//   resetb        asynchronous active-low reset
//   start         launch an operation (sampled only in IDLE)
//   multdivb      1 = multiply, 0 = divide
//   signedop      1 = two's-complement operands
//   abort         cancel the operation in flight
//   x, y          multiplicand/dividend, multiplier/divisor
//   prodh, prodl  mult: high/low product halves; div: remainder/quotient
//   run           operation in flight
//   done          one-cycle pulse when prodh/prodl are updated
//   dividebyzero  set by a divide by zero; stays set until the next accepted start
module multdiv_seq_param #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          MUL_RADIX4 = 1'b0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             multdivb,
  input  logic             signedop,
  input  logic             abort,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] prodh,
  output logic [WIDTH-1:0] prodl,
  output logic             run,
  output logic             done,
  output logic             dividebyzero
);

  localparam int unsigned CntW    = $clog2(WIDTH) + 1;
  localparam int unsigned MulIter = MUL_RADIX4 ? WIDTH / 2 : WIDTH;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 mul_q, mul_d;
  logic                 neg_lo_q, neg_lo_d;   // negate product / quotient
  logic                 neg_hi_q, neg_hi_d;   // negate remainder
  logic                 dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]     prodh_q, prodh_d;
  logic [WIDTH-1:0]     prodl_q, prodl_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     x_abs, y_abs;
  logic [WIDTH:0]       mul2_sum;
  logic [WIDTH+1:0]     mul4_mult, mul4_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [2*WIDTH-1:0]   mul_step, div_step;

  assign x_abs = (signedop && x[WIDTH-1]) ? -x : x;
  assign y_abs = (signedop && y[WIDTH-1]) ? -y : y;

  // Datapath steps, evaluated every cycle. Only the one for the current state is used.
  always_comb begin
    mul2_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    unique case (acc_q[1:0])
      2'd0:    mul4_mult = '0;
      2'd1:    mul4_mult = {2'b00, opnd_q};
      2'd2:    mul4_mult = {1'b0, opnd_q, 1'b0};
      default: mul4_mult = {2'b00, opnd_q} + {1'b0, opnd_q, 1'b0};
    endcase
    mul4_sum = {2'b00, acc_q[2*WIDTH-1:WIDTH]} + mul4_mult;

    if (MUL_RADIX4) mul_step = {mul4_sum, acc_q[WIDTH-1:2]};
    else            mul_step = {mul2_sum, acc_q[WIDTH-1:1]};

    // The remainder is always below the divisor, so the (W+1)-bit difference cannot
    // overflow. Its MSB is a clean borrow flag.
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!div_trial[WIDTH]) div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                   div_step = {acc_q[2*WIDTH-2:0], 1'b0};

    prod_fix = neg_lo_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    mul_d      = mul_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    prodh_d    = prodh_q;
    prodl_d    = prodl_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          mul_d      = multdivb;
          neg_lo_d   = signedop & (x[WIDTH-1] ^ y[WIDTH-1]);
          neg_hi_d   = signedop & x[WIDTH-1];
          dbz_d      = 1'b0;
          dbz_pend_d = 1'b0;
          if (multdivb) begin
            acc_d   = {{WIDTH{1'b0}}, y_abs};
            opnd_d  = x_abs;
            cnt_d   = CntW'(MulIter);
            state_d = StMul;
          end else if (y == '0) begin
            // The raw dividend is parked in the high half for prodh.
            acc_d      = {x, {WIDTH{1'b0}}};
            dbz_pend_d = 1'b1;
            state_d    = StFix;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, x_abs};
            opnd_d  = y_abs;
            cnt_d   = CntW'(WIDTH);
            state_d = StDiv;
          end
        end
      end
      StMul, StDiv: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_d = (state_q == StMul) ? mul_step : div_step;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StFix;
        end
      end
      default: begin // StFix
        state_d = StIdle;
        if (!abort) begin
          done_d = 1'b1;
          if (dbz_pend_q) begin
            prodh_d = acc_q[2*WIDTH-1:WIDTH];
            prodl_d = '1;
            dbz_d   = 1'b1;
          end else if (mul_q) begin
            prodh_d = prod_fix[2*WIDTH-1:WIDTH];
            prodl_d = prod_fix[WIDTH-1:0];
          end else begin
            prodh_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            prodl_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end
      end
    endcase

    run_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      mul_q      <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      prodh_q    <= '0;
      prodl_q    <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      mul_q      <= mul_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      prodh_q    <= prodh_d;
      prodl_q    <= prodl_d;
      run_q      <= run_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign prodh        = prodh_q;
  assign prodl        = prodl_q;
  assign run          = run_q;
  assign done         = done_q;
  assign dividebyzero = dbz_q;

endmodule
